syncupdown_mod: RTL and testbench
=================================

# syncupdown_mod

Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear, count enable and selectable wrap/saturate behaviour. It is the general-purpose counter primitive for timers, BCD digit chains and address generators. Terminal-count and wrap outputs allow instances to be cascaded into multi-digit counters.

## Interface
- WIDTH, 4, counter width in bits (2..32)
- MAX, 2**WIDTH-1, highest count value; counter range is 0..MAX; must satisfy 1 <= MAX <= 2**WIDTH-1
- SAT, 0, 0 = wrap at range ends, 1 = saturate at range ends

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load of din
- din  input  WIDTH  load value
- en  input  1  count enable
- m  input  1  direction: 1 = up, 0 = down
- count  output  WIDTH  registered counter value
- tc  output  1  combinational terminal count: en & ((m & count==MAX) | (~m & count==0))
- wrap  output  1  registered one-cycle pulse, high the cycle after a wrap occurred
- sat  output  1  registered, high while SAT=1 and count sits at the end of the range in the current direction

## Operation
- Reset (rst=0, asynchronous): count=0, wrap=0, sat=0. tc follows its equation and is 1 only if en=1 and m=0.
- Per-edge priority: clr > load > en > hold.
- clr=1: count<=0, wrap<=0.
- load=1 (clr=0): count<=din if din<=MAX, else count<=MAX (clamp). wrap<=0.
- en=1, m=1:
  - count<MAX: count<=count+1.
  - count==MAX with SAT=0: count<=0, wrap<=1.
  - count==MAX with SAT=1: count holds.
- en=1, m=0:
  - count>0: count<=count-1.
  - count==0 with SAT=0: count<=MAX, wrap<=1.
  - count==0 with SAT=1: count holds.
- en=0: count holds, wrap<=0.
- wrap is never asserted when SAT=1.
- Width rule: next-count arithmetic is WIDTH bits. The MAX comparison is explicit, so when MAX < 2**WIDTH-1 no value above MAX is ever reached by counting.
- sat (SAT=1 only) = registered ((m & next==MAX) | (~m & next==0)). Tied to 0 when SAT=0.
- Cascading rule: a higher digit's en is driven from the lower digit's tc. Both instances share m.

## Timing
- Latency: count reflects clr/load/en one clock after the sampling edge.
- tc is combinational from count, en and m, with no register stage, so it is valid in the same cycle as the wrapping increment it predicts.
- wrap is high for exactly one cycle, in the cycle following the edge that wrapped.
- A direction change takes effect on the next enabled edge; there is no dead cycle.
- Reset mid-count: count goes to 0 immediately, without waiting for a clock edge. After rst deasserts, the first active edge applies normal priority.
- Simultaneous clr and load: clr wins.
- Simultaneous load and en: the load wins and the count step is discarded.
- Inputs must be stable around the rising edge of clk. rst deassertion is assumed synchronised externally.

## Test plan
- Reset and count up, WIDTH=4, MAX=9, SAT=0, m=1, en=1: count runs 0..9 then 0. tc=1 while count=9. wrap=1 for one cycle, in the cycle count=0.
- Count down, same parameters, m=0, starting from load din=2: count runs 2,1,0,9,8. tc=1 at count=0. wrap pulses with count=9.
- Saturate, SAT=1, MAX=9, m=1 from 7: count runs 8,9,9,9. sat=1 from count=9 on, wrap stays 0. Then m=0: count runs 8,7 and sat=0.
- Load and priority, MAX=9: din=12 with load=1 gives count=9 (clamp). clr=1 and load=1 with din=5 gives count=0. load=1 and en=1 with din=3 gives count=3, not 4.
- Async reset mid-operation: assert rst=0 while count=6, between clock edges. count=0 immediately, and wrap=0 and sat=0. Release rst: counting resumes 1,2,… on subsequent edges.
- Cascade of two instances, MAX=9, high digit en driven by low digit tc: 00 up to 99, then 00. In down mode 00 goes to 99.

Source files
------------

// File: rtl/syncupdown_mod.sv
// syncupdown_mod: general-purpose up/down counter with programmable modulus,
// parallel load, synchronous clear and selectable wrap/saturate range ends.
// tc is combinational so that cascaded digits can step in the same edge.
module syncupdown_mod #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}},
    parameter bit               SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             m,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             sat_next;
    logic             at_top;
    logic             at_bot;

    // Loaded values above the modulus are pulled back onto the range end.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] value);
        return (value > MAX) ? MAX : value;
    endfunction

    // Saturation flag reflects where the counter will sit for the direction in use.
    function automatic logic sat_flag(input logic [WIDTH-1:0] value, input logic dir_up);
        return SAT && ((dir_up && (value == MAX)) || (!dir_up && (value == '0)));
    endfunction

    assign at_top = (count == MAX);
    assign at_bot = (count == '0);

    // Terminal count predicts the wrap of the coming enabled edge, no register stage.
    assign tc = en & ((m & at_top) | (~m & at_bot));

    // Next-state selection with priority clr > load > en > hold.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = clamp_to_max(din);
        end else if (en) begin
            if (m) begin
                if (!at_top) begin
                    count_next = count + 1'b1;
                end else if (!SAT) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    count_next = count - 1'b1;
                end else if (!SAT) begin
                    count_next = MAX;
                    wrap_next  = 1'b1;
                end
            end
        end
        sat_next = sat_flag(count_next, m);
    end

    // State registers; reset clears immediately without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
            sat   <= sat_next;
        end
    end

endmodule

// File: tb/tb_syncupdown_mod.sv
// Directed bench for syncupdown_mod: wrap instance, saturate instance and a
// two-digit decimal cascade, all with MAX=9 and WIDTH=4.
module tb_syncupdown_mod;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // wrapping instance
    logic       w_clr = 1'b0, w_load = 1'b0, w_en = 1'b0, w_m = 1'b0;
    logic [3:0] w_din = 4'd0;
    logic [3:0] w_count;
    logic       w_tc, w_wrap, w_sat;

    // saturating instance
    logic       s_clr = 1'b0, s_load = 1'b0, s_en = 1'b0, s_m = 1'b0;
    logic [3:0] s_din = 4'd0;
    logic [3:0] s_count;
    logic       s_tc, s_wrap, s_sat;

    // cascade
    logic       c_en = 1'b0, c_m = 1'b1;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, lo_wrap, lo_sat, hi_tc, hi_wrap, hi_sat;

    always #5 clk = ~clk;

    syncupdown_mod #(.WIDTH(4), .MAX(4'd9), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(w_clr), .load(w_load), .din(w_din),
        .en(w_en), .m(w_m), .count(w_count), .tc(w_tc), .wrap(w_wrap), .sat(w_sat)
    );

    syncupdown_mod #(.WIDTH(4), .MAX(4'd9), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(s_clr), .load(s_load), .din(s_din),
        .en(s_en), .m(s_m), .count(s_count), .tc(s_tc), .wrap(s_wrap), .sat(s_sat)
    );

    syncupdown_mod #(.WIDTH(4), .MAX(4'd9), .SAT(1'b0)) u_lo (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .din(4'd0),
        .en(c_en), .m(c_m), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .sat(lo_sat)
    );

    syncupdown_mod #(.WIDTH(4), .MAX(4'd9), .SAT(1'b0)) u_hi (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .din(4'd0),
        .en(lo_tc), .m(c_m), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .sat(hi_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one rising edge, then return on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1 rst = 1'b0;
        w_en = 1'b1;
        w_m  = 1'b0;
        #1;
        chk("rst_count", w_count, 0);
        chk("rst_wrap", w_wrap, 0);
        chk("rst_sat", w_sat, 0);
        chk("rst_tc_down_en", w_tc, 1);
        w_m = 1'b1;
        #1;
        chk("rst_tc_up_en", w_tc, 0);
        chk("rst_s_sat", s_sat, 0);

        // ---------------- count up with wrap ----------------
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("up_count_%0d", i), w_count, i % 10);
            chk($sformatf("up_tc_%0d", i), w_tc, (i == 9) ? 1 : 0);
            chk($sformatf("up_wrap_%0d", i), w_wrap, (i == 10) ? 1 : 0);
            chk($sformatf("up_sat_%0d", i), w_sat, 0);
        end
        step();
        chk("up_after_wrap_count", w_count, 1);
        chk("up_wrap_one_cycle", w_wrap, 0);

        // ---------------- count down from load 2 ----------------
        w_load = 1'b1;
        w_din  = 4'd2;
        step();
        chk("dn_load_count", w_count, 2);
        w_load = 1'b0;
        w_m    = 1'b0;
        begin
            logic [3:0] dn_cnt [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
            logic       dn_tc  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
            logic       dn_wr  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                step();
                chk($sformatf("dn_count_%0d", i), w_count, dn_cnt[i]);
                chk($sformatf("dn_tc_%0d", i), w_tc, dn_tc[i]);
                chk($sformatf("dn_wrap_%0d", i), w_wrap, dn_wr[i]);
            end
        end

        // ---------------- load clamp and priority ----------------
        w_en   = 1'b0;
        w_load = 1'b1;
        w_din  = 4'd12;
        step();
        chk("clamp_count", w_count, 9);
        w_clr = 1'b1;
        w_din = 4'd5;
        step();
        chk("clr_over_load", w_count, 0);
        w_clr = 1'b0;
        w_en  = 1'b1;
        w_m   = 1'b1;
        w_din = 4'd3;
        step();
        chk("load_over_en", w_count, 3);
        chk("load_wrap", w_wrap, 0);

        // ---------------- saturate ----------------
        s_load = 1'b1;
        s_din  = 4'd7;
        s_m    = 1'b1;
        step();
        chk("sat_load7", s_count, 7);
        chk("sat_load7_sat", s_sat, 0);
        s_load = 1'b0;
        s_en   = 1'b1;
        begin
            logic [3:0] su_cnt [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
            logic       su_sat [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 4; i++) begin
                step();
                chk($sformatf("satup_count_%0d", i), s_count, su_cnt[i]);
                chk($sformatf("satup_sat_%0d", i), s_sat, su_sat[i]);
                chk($sformatf("satup_wrap_%0d", i), s_wrap, 0);
            end
        end
        chk("sat_tc_top", s_tc, 1);
        s_m = 1'b0;
        step();
        chk("satdn_count_0", s_count, 8);
        chk("satdn_sat_0", s_sat, 0);
        step();
        chk("satdn_count_1", s_count, 7);
        chk("satdn_sat_1", s_sat, 0);
        s_en   = 1'b0;
        s_load = 1'b1;
        s_din  = 4'd0;
        step();
        chk("satlo_load0", s_count, 0);
        chk("satlo_load0_sat", s_sat, 1);
        s_load = 1'b0;
        s_en   = 1'b1;
        step();
        chk("satlo_hold", s_count, 0);
        chk("satlo_sat", s_sat, 1);
        chk("satlo_wrap", s_wrap, 0);

        // ---------------- async reset mid-operation ----------------
        w_en   = 1'b0;
        w_load = 1'b1;
        w_din  = 4'd6;
        s_en   = 1'b0;
        step();
        chk("ar_pre_count", w_count, 6);
        #2 rst = 1'b0;
        #1;
        chk("ar_count", w_count, 0);
        chk("ar_wrap", w_wrap, 0);
        chk("ar_sat", w_sat, 0);
        chk("ar_s_sat", s_sat, 0);
        @(negedge clk);
        chk("ar_hold_count", w_count, 0);
        rst    = 1'b1;
        w_load = 1'b0;
        w_en   = 1'b1;
        w_m    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("ar_resume_%0d", i), w_count, i);
        end

        // ---------------- two-digit cascade ----------------
        c_m  = 1'b1;
        c_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk($sformatf("cas_lo_%0d", i), lo_count, (i % 100) % 10);
            chk($sformatf("cas_hi_%0d", i), hi_count, (i % 100) / 10);
            chk($sformatf("cas_lowrap_%0d", i), lo_wrap, (i % 10 == 0) ? 1 : 0);
            chk($sformatf("cas_hiwrap_%0d", i), hi_wrap, (i == 100) ? 1 : 0);
            chk($sformatf("cas_hitc_%0d", i), hi_tc, (i == 99) ? 1 : 0);
        end
        c_m = 1'b0;
        step();
        chk("cas_dn_lo", lo_count, 9);
        chk("cas_dn_hi", hi_count, 9);
        chk("cas_dn_lowrap", lo_wrap, 1);
        chk("cas_dn_hiwrap", hi_wrap, 1);
        step();
        chk("cas_dn2_lo", lo_count, 8);
        chk("cas_dn2_hi", hi_count, 9);
        chk("cas_lo_sat", lo_sat, 0);
        chk("cas_hi_sat", hi_sat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
